// File: rtl/ictrl_noc_to_ibuffer_write_if.sv
// Bundle between the NoC read-data port, the start/done control and the ibuffer write port.
// The master modport is the surrounding controller; slave is the NoC-to-ibuffer writer.
interface ictrl_noc_to_ibuffer_write_if #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned MEM_AW     = 15,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned OW         = $clog2(DATA_WIDTH / WORD_WIDTH)
);
    logic [MEM_AW+OW-1:0]  ibuffer_word_addr;
    logic [12:0]           ibuffer_word_num;
    logic                  noc_rd_start;
    logic                  noc_rd_done;
    logic                  noc_rd_valid;
    logic                  noc_rd_ready;
    logic [WORD_WIDTH-1:0] noc_rd_data;
    logic                  noc_rd_last;
    logic                  noc_rd_last_err;
    logic                  ibuffer_cen;
    logic                  ibuffer_wen;
    logic                  ibuffer_ready;
    logic [MEM_AW-1:0]     ibuffer_addr;
    logic [DATA_WIDTH-1:0] ibuffer_wdata;
    logic [STRB_WIDTH-1:0] ibuffer_wstrb;

    modport master (
        output ibuffer_word_addr, ibuffer_word_num, noc_rd_start,
        output noc_rd_valid, noc_rd_data, noc_rd_last, ibuffer_ready,
        input  noc_rd_done, noc_rd_ready, noc_rd_last_err,
        input  ibuffer_cen, ibuffer_wen, ibuffer_addr, ibuffer_wdata, ibuffer_wstrb
    );

    modport slave (
        input  ibuffer_word_addr, ibuffer_word_num, noc_rd_start,
        input  noc_rd_valid, noc_rd_data, noc_rd_last, ibuffer_ready,
        output noc_rd_done, noc_rd_ready, noc_rd_last_err,
        output ibuffer_cen, ibuffer_wen, ibuffer_addr, ibuffer_wdata, ibuffer_wstrb
    );
endinterface

// File: rtl/ictrl_noc_to_ibuffer_write.sv
// Packs 32-bit NoC words into strobed ibuffer lines through a pack stage and a write stage.
// Optional ICTRL_NOC_WR_LAST_CHECK_EN enables the sticky noc_rd_last mismatch flag.
module ictrl_noc_to_ibuffer_write #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned MEM_AW     = 15,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic clk,
    input  logic rst_n,
    ictrl_noc_to_ibuffer_write_if.slave bus
);
    localparam int unsigned WordNum      = DATA_WIDTH / WORD_WIDTH;
    localparam int unsigned Ow           = $clog2(WordNum);
    localparam int unsigned BytesPerWord = WORD_WIDTH / 8;

    logic                  busy_q, busy_d;
    logic [12:0]           num_q, num_d, cnt_q, cnt_d;
    logic [MEM_AW-1:0]     line_addr_q, line_addr_d;
    logic [Ow-1:0]         off_q, off_d;
    logic [DATA_WIDTH-1:0] pack_data_q, pack_data_d;
    logic [WordNum-1:0]    pack_mask_q, pack_mask_d;
    logic                  pack_held_q, pack_held_d;
    logic                  pack_last_q, pack_last_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [MEM_AW-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [STRB_WIDTH-1:0] wr_strb_q, wr_strb_d;
    logic                  wr_last_q, wr_last_d;
    logic                  last_err_q, last_err_d;

    logic                  wr_hs, word_ready, word_hs, last_word, done, start_ok;
    logic                  completes, line_done, line_last, move;
    logic [DATA_WIDTH-1:0] data_m;
    logic [WordNum-1:0]    mask_m;

    always_comb begin
        wr_hs      = wr_valid_q & bus.ibuffer_ready;
        word_ready = busy_q & (cnt_q < num_q) & ~pack_held_q;
        word_hs    = bus.noc_rd_valid & word_ready;
        last_word  = (cnt_q == num_q - 13'd1);
        done       = wr_hs & wr_last_q;
        start_ok   = bus.noc_rd_start & ~busy_q & (bus.ibuffer_word_num != 13'd0);

        data_m = pack_data_q;
        mask_m = pack_mask_q;
        for (int unsigned k = 0; k < WordNum; k++) begin
            if (word_hs && off_q == Ow'(k)) begin
                data_m[k*WORD_WIDTH +: WORD_WIDTH] = bus.noc_rd_data;
                mask_m[k]                          = 1'b1;
            end
        end

        completes = word_hs & ((off_q == Ow'(WordNum - 1)) | last_word);
        line_done = completes | pack_held_q;
        line_last = completes ? last_word : pack_last_q;
        // A finished line may enter the write stage if it is empty or draining this cycle.
        move      = line_done & (~wr_valid_q | wr_hs);
    end

    always_comb begin
        busy_d      = busy_q;
        num_d       = num_q;
        cnt_d       = cnt_q;
        line_addr_d = line_addr_q;
        off_d       = off_q;
        pack_data_d = data_m;
        pack_mask_d = mask_m;
        pack_held_d = pack_held_q;
        pack_last_d = pack_last_q;
        wr_valid_d  = wr_valid_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_strb_d   = wr_strb_q;
        wr_last_d   = wr_last_q;
        last_err_d  = last_err_q;

        if (word_hs) begin
            cnt_d = cnt_q + 13'd1;
            off_d = off_q + Ow'(1);
        end

        if (move) begin
            wr_valid_d  = 1'b1;
            wr_addr_d   = line_addr_q;
            wr_data_d   = data_m;
            wr_last_d   = line_last;
            for (int unsigned k = 0; k < WordNum; k++) begin
                wr_strb_d[k*BytesPerWord +: BytesPerWord] = {BytesPerWord{mask_m[k]}};
            end
            line_addr_d = line_addr_q + MEM_AW'(1);
            pack_data_d = '0;
            pack_mask_d = '0;
            pack_held_d = 1'b0;
            pack_last_d = 1'b0;
        end else begin
            if (wr_hs) begin
                wr_valid_d = 1'b0;
            end
            if (line_done) begin
                pack_held_d = 1'b1;
                pack_last_d = line_last;
            end
        end

        if (done) begin
            busy_d = 1'b0;
        end

`ifdef ICTRL_NOC_WR_LAST_CHECK_EN
        if (word_hs && (bus.noc_rd_last != last_word)) begin
            last_err_d = 1'b1;
        end
`endif

        if (start_ok) begin
            busy_d      = 1'b1;
            num_d       = bus.ibuffer_word_num;
            cnt_d       = 13'd0;
            line_addr_d = bus.ibuffer_word_addr[Ow +: MEM_AW];
            off_d       = bus.ibuffer_word_addr[Ow-1:0];
            last_err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            num_q       <= '0;
            cnt_q       <= '0;
            line_addr_q <= '0;
            off_q       <= '0;
            pack_data_q <= '0;
            pack_mask_q <= '0;
            pack_held_q <= 1'b0;
            pack_last_q <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_strb_q   <= '0;
            wr_last_q   <= 1'b0;
            last_err_q  <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            num_q       <= num_d;
            cnt_q       <= cnt_d;
            line_addr_q <= line_addr_d;
            off_q       <= off_d;
            pack_data_q <= pack_data_d;
            pack_mask_q <= pack_mask_d;
            pack_held_q <= pack_held_d;
            pack_last_q <= pack_last_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_strb_q   <= wr_strb_d;
            wr_last_q   <= wr_last_d;
            last_err_q  <= last_err_d;
        end
    end

`ifndef ICTRL_NOC_WR_LAST_CHECK_EN
    logic unused_last;
    assign unused_last = bus.noc_rd_last;
`endif

    assign bus.noc_rd_ready    = word_ready;
    assign bus.noc_rd_done     = done;
    assign bus.noc_rd_last_err = last_err_q;
    assign bus.ibuffer_cen     = wr_valid_q;
    assign bus.ibuffer_wen     = wr_valid_q;
    assign bus.ibuffer_addr    = wr_addr_q;
    assign bus.ibuffer_wdata   = wr_data_q;
    assign bus.ibuffer_wstrb   = wr_strb_q;
endmodule

// File: tb/tb_ictrl_noc_to_ibuffer_write.sv
// Directed bench for ictrl_noc_to_ibuffer_write: aligned, unaligned, backpressure, bursty,
// last-marker and mid-transfer reset scenarios with hand-computed line contents.
module tb_ictrl_noc_to_ibuffer_write;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ictrl_noc_to_ibuffer_write_if bus_if ();

    ictrl_noc_to_ibuffer_write dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

`ifdef ICTRL_NOC_WR_LAST_CHECK_EN
    localparam bit LastChk = 1'b1;
`else
    localparam bit LastChk = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [14:0]  wa [64];
    logic [127:0] wd [64];
    logic [15:0]  ws [64];
    int n_wr      = 0;
    int done_cnt  = 0;
    int done_at   = 0;
    int bad_done  = 0;

    // Write-port monitor; sampled on the falling edge.
    always @(negedge clk) begin
        if (bus_if.ibuffer_cen && bus_if.ibuffer_ready) begin
            wa[n_wr] <= bus_if.ibuffer_addr;
            wd[n_wr] <= bus_if.ibuffer_wdata;
            ws[n_wr] <= bus_if.ibuffer_wstrb;
            n_wr     <= n_wr + 1;
        end
        if (bus_if.noc_rd_done) begin
            done_cnt <= done_cnt + 1;
            done_at  <= n_wr + ((bus_if.ibuffer_cen && bus_if.ibuffer_ready) ? 1 : 0);
            if (!(bus_if.ibuffer_cen && bus_if.ibuffer_ready)) bad_done <= bad_done + 1;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [16:0] addr, input logic [12:0] num, input logic [31:0] base,
                        input bit bursty, input int last_idx, input int stall_from,
                        input int stall_len, input logic [14:0] stall_addr,
                        input logic [127:0] stall_data, input int rdy_c);
        int idx = 0;
        int c   = 0;
        int d0  = done_cnt;
        @(posedge clk); #1;
        bus_if.noc_rd_start      = 1'b1;
        bus_if.ibuffer_word_addr = addr;
        bus_if.ibuffer_word_num  = num;
        bus_if.noc_rd_valid      = 1'b0;
        while (done_cnt == d0 && c < 200) begin
            @(posedge clk); #1;
            bus_if.noc_rd_start  = 1'b0;
            bus_if.ibuffer_ready = !(c >= stall_from && c < stall_from + stall_len);
            bus_if.noc_rd_valid  = (idx < int'(num)) && (!bursty || (c % 2 == 0));
            bus_if.noc_rd_data   = base + 32'(idx);
            bus_if.noc_rd_last   = (idx == last_idx);
            @(negedge clk);
            if (stall_len > 0 && c >= stall_from && c < stall_from + stall_len) begin
                check("stall_cen", bus_if.ibuffer_cen, 1'b1);
                check("stall_addr", bus_if.ibuffer_addr, stall_addr);
                check("stall_wdata", bus_if.ibuffer_wdata, stall_data);
            end
            if (c == rdy_c)     check("rdy_before_hold", bus_if.noc_rd_ready, 1'b1);
            if (c == rdy_c + 1) check("rdy_held_low", bus_if.noc_rd_ready, 1'b0);
            if (bus_if.noc_rd_valid && bus_if.noc_rd_ready) idx++;
            c++;
        end
        check("xfer_done_seen", done_cnt != d0, 1'b1);
        check("xfer_words_sent", idx, num);
        @(posedge clk); #1;
        bus_if.noc_rd_valid  = 1'b0;
        bus_if.noc_rd_last   = 1'b0;
        bus_if.ibuffer_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    int b;
    int d;

    initial begin
        bus_if.ibuffer_word_addr = '0;
        bus_if.ibuffer_word_num  = '0;
        bus_if.noc_rd_start      = 1'b0;
        bus_if.noc_rd_valid      = 1'b0;
        bus_if.noc_rd_data       = '0;
        bus_if.noc_rd_last       = 1'b0;
        bus_if.ibuffer_ready     = 1'b1;

        // Reset values
        #12;
        check("rst_ready", bus_if.noc_rd_ready, 1'b0);
        check("rst_done", bus_if.noc_rd_done, 1'b0);
        check("rst_err", bus_if.noc_rd_last_err, 1'b0);
        check("rst_cen", bus_if.ibuffer_cen, 1'b0);
        check("rst_wen", bus_if.ibuffer_wen, 1'b0);
        check("rst_addr", bus_if.ibuffer_addr, 15'h0);
        check("rst_wdata", bus_if.ibuffer_wdata, 128'h0);
        check("rst_wstrb", bus_if.ibuffer_wstrb, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start with num=0 is ignored
        d = done_cnt;
        @(posedge clk); #1;
        bus_if.noc_rd_start     = 1'b1;
        bus_if.ibuffer_word_num = 13'd0;
        @(posedge clk); #1;
        bus_if.noc_rd_start = 1'b0;
        @(negedge clk);
        check("num0_ready", bus_if.noc_rd_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("num0_no_done", done_cnt, d);

        // Aligned: addr 0x10, num 8
        b = n_wr;
        d = done_cnt;
        xfer(17'h10, 13'd8, 32'h1000_0000, 1'b0, 7, 0, 0, 15'h0, 128'h0, -5);
        check("al_nwr", n_wr - b, 2);
        check("al_addr0", wa[b], 15'h4);
        check("al_strb0", ws[b], 16'hFFFF);
        check("al_data0", wd[b], 128'h10000003_10000002_10000001_10000000);
        check("al_addr1", wa[b+1], 15'h5);
        check("al_strb1", ws[b+1], 16'hFFFF);
        check("al_data1", wd[b+1], 128'h10000007_10000006_10000005_10000004);
        check("al_done_cnt", done_cnt - d, 1);
        check("al_done_at", done_at, b + 2);

        // Unaligned: addr 0x03, num 6
        b = n_wr;
        d = done_cnt;
        xfer(17'h03, 13'd6, 32'h2000_0000, 1'b0, 5, 0, 0, 15'h0, 128'h0, -5);
        check("ua_nwr", n_wr - b, 3);
        check("ua_addr0", wa[b], 15'h0);
        check("ua_strb0", ws[b], 16'hF000);
        check("ua_data0", wd[b], 128'h20000000_00000000_00000000_00000000);
        check("ua_addr1", wa[b+1], 15'h1);
        check("ua_strb1", ws[b+1], 16'hFFFF);
        check("ua_data1", wd[b+1], 128'h20000004_20000003_20000002_20000001);
        check("ua_addr2", wa[b+2], 15'h2);
        check("ua_strb2", ws[b+2], 16'h000F);
        check("ua_data2", wd[b+2], 128'h00000000_00000000_00000000_20000005);
        check("ua_done_cnt", done_cnt - d, 1);

        // Backpressure: ibuffer_ready low for cycles 4..8 while line 0 is presented
        b = n_wr;
        d = done_cnt;
        xfer(17'h00, 13'd8, 32'h3000_0000, 1'b0, 7, 4, 5, 15'h0,
             128'h30000003_30000002_30000001_30000000, 7);
        check("bp_nwr", n_wr - b, 2);
        check("bp_data0", wd[b], 128'h30000003_30000002_30000001_30000000);
        check("bp_addr1", wa[b+1], 15'h1);
        check("bp_data1", wd[b+1], 128'h30000007_30000006_30000005_30000004);
        check("bp_done_cnt", done_cnt - d, 1);

        // Bursty NoC: valid on alternate cycles, addr 0x08, num 5
        b = n_wr;
        d = done_cnt;
        xfer(17'h08, 13'd5, 32'h4000_0000, 1'b1, 4, 0, 0, 15'h0, 128'h0, -5);
        check("bu_nwr", n_wr - b, 2);
        check("bu_addr0", wa[b], 15'h2);
        check("bu_data0", wd[b], 128'h40000003_40000002_40000001_40000000);
        check("bu_addr1", wa[b+1], 15'h3);
        check("bu_strb1", ws[b+1], 16'h000F);
        check("bu_data1", wd[b+1], 128'h00000000_00000000_00000000_40000004);
        check("bu_done_cnt", done_cnt - d, 1);

        // Last marker on word 2 of 4
        b = n_wr;
        xfer(17'h00, 13'd4, 32'h5000_0000, 1'b0, 2, 0, 0, 15'h0, 128'h0, -5);
        check("lm_nwr", n_wr - b, 1);
        check("lm_data0", wd[b], 128'h50000003_50000002_50000001_50000000);
        check("lm_err", bus_if.noc_rd_last_err, LastChk);
        repeat (4) @(posedge clk);
        #1;
        check("lm_err_sticky", bus_if.noc_rd_last_err, LastChk);
        b = n_wr;
        xfer(17'h40, 13'd4, 32'h6000_0000, 1'b0, 3, 0, 0, 15'h0, 128'h0, -5);
        check("lm_err_cleared", bus_if.noc_rd_last_err, 1'b0);
        check("lm2_addr0", wa[b], 15'h10);

        // Reset mid-transfer with a line stalled in the write stage
        b = n_wr;
        @(posedge clk); #1;
        bus_if.noc_rd_start      = 1'b1;
        bus_if.ibuffer_word_addr = 17'h10;
        bus_if.ibuffer_word_num  = 13'd8;
        bus_if.ibuffer_ready     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus_if.noc_rd_start = 1'b0;
            bus_if.noc_rd_valid = 1'b1;
            bus_if.noc_rd_data  = 32'hDEAD_0000 + 32'(i);
        end
        @(posedge clk); #1;
        bus_if.noc_rd_valid = 1'b0;
        check("mr_cen_before", bus_if.ibuffer_cen, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_cen", bus_if.ibuffer_cen, 1'b0);
        check("mr_ready", bus_if.noc_rd_ready, 1'b0);
        check("mr_strb", bus_if.ibuffer_wstrb, 16'h0);
        check("mr_nwr", n_wr - b, 0);
        @(negedge clk);
        rst_n                = 1'b1;
        bus_if.ibuffer_ready = 1'b1;
        d = done_cnt;
        xfer(17'h00, 13'd4, 32'h7000_0000, 1'b0, 3, 0, 0, 15'h0, 128'h0, -5);
        check("rs_nwr", n_wr - b, 1);
        check("rs_addr0", wa[b], 15'h0);
        check("rs_strb0", ws[b], 16'hFFFF);
        check("rs_data0", wd[b], 128'h70000003_70000002_70000001_70000000);
        check("rs_done_cnt", done_cnt - d, 1);

        check("done_only_on_hs", bad_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ictrl_noc_to_ibuffer_write.md
# ictrl_noc_to_ibuffer_write

Receive-side counterpart of the ibuffer-to-NoC reader in `ictrl`. It accepts a stream of 32-bit words from the NoC and packs them into DATA_WIDTH-bit lines. It writes those lines into the ibuffer with per-byte strobes, and supports unaligned start word addresses and partial first and last lines. It sits between the NoC read-data port and the ibuffer SRAM port, and signals completion once the final line write has been accepted.

## Interface
- DATA_WIDTH, 128, ibuffer line width in bits
- MEM_AW, 15, ibuffer line address width
- WORD_WIDTH, 32, NoC word width in bits
- STRB_WIDTH, DATA_WIDTH/8, byte strobe width
- Derived: WORD_NUM = DATA_WIDTH/WORD_WIDTH (4); OW = $clog2(WORD_NUM) (2)

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- ibuffer_word_addr  in  MEM_AW+OW  start word address; sampled on noc_rd_start
- ibuffer_word_num  in  13  number of words; sampled on noc_rd_start
- noc_rd_start  in  1  one-cycle start pulse
- noc_rd_done  out  1  one-cycle pulse on the handshake of the final ibuffer write
- noc_rd_valid  in  1  NoC word valid
- noc_rd_ready  out  1  word accepted when valid && ready
- noc_rd_data  in  WORD_WIDTH  NoC word
- noc_rd_last  in  1  NoC marks the final word
- noc_rd_last_err  out  1  sticky last-marker mismatch flag (see Configuration)
- ibuffer_cen  out  1  ibuffer request
- ibuffer_wen  out  1  write enable; 1 whenever ibuffer_cen=1
- ibuffer_ready  in  1  request accepted when cen && ready
- ibuffer_addr  out  MEM_AW  line address
- ibuffer_wdata  out  DATA_WIDTH  packed line
- ibuffer_wstrb  out  STRB_WIDTH  byte strobes

## Operation
- Idle until noc_rd_start arrives with ibuffer_word_num != 0.
  - On start: latch num; line_addr = word_addr[OW +: MEM_AW]; word_offset = word_addr[OW-1:0]; word counter = 0; busy = 1.
  - noc_rd_start while busy is ignored. Start with num = 0 is ignored: busy stays 0 and no done pulse is issued.
- Pack stage: one line register plus a per-word valid mask.
  - An accepted word is written to lane word_offset, sets that lane's mask bit, and increments word_offset (mod WORD_NUM) and the word counter.
  - The line completes when word_offset == WORD_NUM-1 or the counter reaches num-1.
- Write stage: one line register, write address, strobe, and a wr_valid flag.
  - A completed line moves to the write stage in the same edge that it completes, if wr_valid == 0 or the write stage is handshaking that cycle.
  - Otherwise it is held, and noc_rd_ready = 0 until it moves.
  - On each move, line_addr increments by 1 and the pack mask clears.
- noc_rd_ready = busy && word counter < num && !(pack line complete and held).
- ibuffer_cen = wr_valid. ibuffer_wstrb has bits [4k+3:4k] set for each valid lane k. Invalid lanes carry zero in ibuffer_wdata.
- Termination:
  - noc_rd_done = handshake && (this write holds the last word).
  - busy clears on the same edge as done.
  - Number of lines written = (addr+num-1)>>OW − addr>>OW + 1.

## Timing
- Reset values: noc_rd_ready=0, noc_rd_done=0, noc_rd_last_err=0, ibuffer_cen=0, ibuffer_wen=0, ibuffer_addr=0, ibuffer_wdata=0, ibuffer_wstrb=0.
- Latency: the word that completes a line is accepted in cycle N; ibuffer_cen=1 in cycle N+1.
- With noc_rd_valid and ibuffer_ready held high, throughput is one word per cycle with no bubbles.
- ibuffer_cen, addr, wdata, and wstrb hold stable while cen && !ready.
- Simultaneous events:
  - Write handshake and a new line completing in the same cycle: the new line loads and cen stays 1.
  - Done and a new noc_rd_start in the same cycle: start is ignored, because busy is still 1.
- Counter arithmetic is 13-bit. Line addresses wrap modulo 2^MEM_AW.
- Asserting rst_n mid-transfer returns the block to idle immediately. Partial data is discarded.

## Configuration
- ICTRL_NOC_WR_LAST_CHECK_EN
  - Defined: noc_rd_last_err sets when an accepted word has noc_rd_last != (counter == num-1). It stays set until the next accepted noc_rd_start. Data flow is unaffected.
  - Undefined: noc_rd_last and the check are ignored, and noc_rd_last_err is tied to 0.

## Test plan
- Aligned transfer: addr=0x10, num=8, ready=1 → two writes at line 0x4 and 0x5, wstrb=0xFFFF each; done pulses on the second handshake.
- Unaligned transfer: addr=0x03, num=6 → three writes: line 0 wstrb=0xF000, line 1 0xFFFF, line 2 0x000F; data lanes match word order.
- Backpressure: ibuffer_ready=0 for 5 cycles on the first line → cen/addr/wdata stable; noc_rd_ready falls once the second line completes; no word is lost.
- Bursty NoC: valid toggles 1010… with num=5 → correct packing, two writes, single done pulse.
- Last mismatch (macro defined): noc_rd_last=1 on word 2 of num=4 → noc_rd_last_err=1 until the next start; the writes are still completed.
- Reset mid-transfer, then restart with addr=0, num=4 → one write, wstrb=0xFFFF, done pulse.
